// File: rtl/mem_resp_pkg.sv
// Shared types and address helpers for the mem_responder data-memory target.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DATA_W        = 32;
    localparam int ADDR_W        = 32;
    localparam int WORD_BYTES    = 4;
    localparam int BYTE_OFS_BITS = 2;
    localparam int INDEX_W       = ADDR_W - BYTE_OFS_BITS;

    function automatic logic [INDEX_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:BYTE_OFS_BITS];
    endfunction

    function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
        return addr[BYTE_OFS_BITS-1:0] != '0;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/ack bus between the datapath memory stage and mem_responder.
// The be lane mask exists only when MEM_RESP_BYTE_STROBE_EN is defined.
interface mem_responder_if;
    import mem_resp_pkg::*;

    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
`ifdef MEM_RESP_BYTE_STROBE_EN
    logic [WORD_BYTES-1:0] be;
`endif
    logic                  busy;
    logic                  ack;
    logic [DATA_W-1:0]     rdata;
    logic                  err;

`ifdef MEM_RESP_BYTE_STROBE_EN
    modport master (output req, we, addr, wdata, be, input busy, ack, rdata, err);
    modport slave  (input req, we, addr, wdata, be, output busy, ack, rdata, err);
`else
    modport master (output req, we, addr, wdata, input busy, ack, rdata, err);
    modport slave  (input req, we, addr, wdata, output busy, ack, rdata, err);
`endif

endinterface

// File: rtl/mem_resp_array.sv
// DEPTH_WORDS x 32 storage: synchronous byte-masked write, asynchronous read.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [WORD_BYTES-1:0] wbe,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    // NOTE: the array has no reset so it maps onto RAM and keeps its contents
    // across rst; non-blocking writes keep same-edge reads seeing the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (wbe[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_responder.sv
// Wait-state data-memory responder with misalignment/range error reporting.
// Byte-lane stores are enabled by defining MEM_RESP_BYTE_STROBE_EN.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    localparam int AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [WORD_BYTES-1:0] wbe;

    logic [INDEX_W-1:0]    index;
    logic                  acc_err;
    logic                  mem_we;
    logic [DATA_W-1:0]     mem_rdata;

`ifdef MEM_RESP_BYTE_STROBE_EN
    logic [WORD_BYTES-1:0] be_q, be_d;
    assign wbe = be_q;
`else
    assign wbe = '1;
`endif

    assign index   = word_index(addr_q);
    assign acc_err = is_misaligned(addr_q) || (index >= INDEX_W'(DEPTH_WORDS));
    assign bus.busy = (state_q != IDLE);

    // NOTE: every output of this block gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
`ifdef MEM_RESP_BYTE_STROBE_EN
        be_d      = be_q;
`endif
        bus.ack   = 1'b0;
        bus.err   = 1'b0;
        bus.rdata = '0;
        mem_we    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    we_d    = bus.we;
`ifdef MEM_RESP_BYTE_STROBE_EN
                    be_d    = bus.be;
`endif
                    cnt_d   = CNT_LOAD;
                    state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.ack   = 1'b1;
                bus.err   = acc_err;
                bus.rdata = (acc_err || we_q) ? '0 : mem_rdata;
                mem_we    = we_q && !acc_err;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
`ifdef MEM_RESP_BYTE_STROBE_EN
            be_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
`ifdef MEM_RESP_BYTE_STROBE_EN
            be_q    <= be_d;
`endif
        end
    end

    // A reset landing in RESP must abort the pending store.
    mem_resp_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we && !rst),
        .addr  (index[AW-1:0]),
        .wdata (wdata_q),
        .wbe   (wbe),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: one instance with WAIT_CYCLES=2, one with 0.
// Byte-lane cases are exercised when MEM_RESP_BYTE_STROBE_EN is defined.
module tb_mem_responder;

    localparam int DEPTH  = 256;
    localparam int WAIT_A = 2;
    localparam int WAIT_B = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference memory: word index -> contents, only for words the bench wrote.
    logic [31:0] model_mem [int unsigned];

    mem_responder_if bus_a ();
    mem_responder_if bus_b ();

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_A)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_B)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    endfunction

    // One transaction on bus_a; optionally disturbs addr/wdata/we after acceptance.
    task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input logic scramble,
                          output logic [31:0] rd, output logic e, output int lat);
        @(negedge clk);
        bus_a.req   = 1'b1;
        bus_a.we    = w;
        bus_a.addr  = a;
        bus_a.wdata = d;
`ifdef MEM_RESP_BYTE_STROBE_EN
        bus_a.be    = b;
`endif
        @(posedge clk); #1;
        if (scramble) begin
            bus_a.addr  = a ^ 32'h0000_0040;
            bus_a.wdata = ~d;
            bus_a.we    = ~w;
        end
        lat = 1;
        rd  = '0;
        e   = 1'b0;
        while (!bus_a.ack && lat <= 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bus_a.ack) begin
            rd = bus_a.rdata;
            e  = bus_a.err;
            check("busy_in_ack", bus_a.busy, 1);
        end else begin
            lat = -1;
        end
        bus_a.req = 1'b0;
        @(posedge clk); #1;
        check("idle_after_ack", {bus_a.rdata[29:0], bus_a.busy, bus_a.ack}, 0);
    endtask

    task automatic txn(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b, input logic scr);
        logic [31:0] rd, exp_rd, old;
        logic        e, exp_err;
        logic [3:0]  eb;
        int          lat;
        int unsigned idx;
        exp_err = model_err(a);
        idx     = a >> 2;
        exp_rd  = '0;
        if (!w && !exp_err) exp_rd = model_mem[idx];
`ifdef MEM_RESP_BYTE_STROBE_EN
        eb = b;
`else
        eb = 4'hF;
`endif
        do_txn(w, a, d, b, scr, rd, e, lat);
        check($sformatf("%s_lat", tag), 32'(lat), 32'(WAIT_A + 1));
        check($sformatf("%s_err", tag), 32'(e), 32'(exp_err));
        if (!w) check($sformatf("%s_rdata", tag), rd, exp_rd);
        if (w && !exp_err) begin
            old = model_mem.exists(idx) ? model_mem[idx] : 32'hx;
            for (int k = 0; k < 4; k++) begin
                if (eb[k]) old[8*k +: 8] = d[8*k +: 8];
            end
            model_mem[idx] = old;
        end
    endtask

    initial begin
        logic [31:0] v0, v1, v2, a, d;
        logic [31:0] vb [2];
        logic [3:0]  ack_seq, busy_seq;
        int          cyc, acks;

        bus_a.req = 1'b0; bus_a.we = 1'b0; bus_a.addr = '0; bus_a.wdata = '0;
        bus_b.req = 1'b0; bus_b.we = 1'b0; bus_b.addr = '0; bus_b.wdata = '0;
`ifdef MEM_RESP_BYTE_STROBE_EN
        bus_a.be = 4'hF;
        bus_b.be = 4'hF;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_busy", bus_a.busy, 0);
        check("rst_a_ack", bus_a.ack, 0);
        check("rst_a_err", bus_a.err, 0);
        check("rst_a_rdata", bus_a.rdata, 0);
        check("rst_b_busy", bus_b.busy, 0);
        check("rst_b_ack", bus_b.ack, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic store/load with wait states.
        txn("st_10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        txn("ld_10", 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);

        // Prefill a window used by the scramble and random sections.
        for (int i = 0; i < 16; i++) begin
            txn("fill", 1'b1, 32'h40 + 32'(4 * i), $urandom, 4'hF, 1'b0);
        end

        // Error cases: misaligned and out-of-range, loads and stores.
        txn("ld_mis", 1'b0, 32'h12, 32'h0, 4'hF, 1'b0);
        txn("ld_oor", 1'b0, 32'(4 * DEPTH), 32'h0, 4'hF, 1'b0);
        txn("st_mis", 1'b1, 32'h11, 32'h0BAD_0BAD, 4'hF, 1'b0);
        txn("st_oor", 1'b1, 32'(4 * DEPTH), 32'h0BAD_0BAD, 4'hF, 1'b0);
        txn("ld_10_again", 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);

        // Reset during WAIT aborts a store.
        v0 = $urandom; v1 = ~v0; v2 = v0 ^ 32'h5A5A_A5A5;
        txn("st_20", 1'b1, 32'h20, v0, 4'hF, 1'b0);
        @(negedge clk);
        bus_a.req = 1'b1; bus_a.we = 1'b1; bus_a.addr = 32'h20; bus_a.wdata = v1;
        @(posedge clk); #1;
        check("rst_wait_busy_before", bus_a.busy, 1);
        rst = 1'b1;
        bus_a.req = 1'b0;
        @(posedge clk); #1;
        check("rst_wait_busy_after", bus_a.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus_a.ack) acks++;
        end
        check("rst_wait_no_ack", 32'(acks), 0);
        txn("ld_20_wait", 1'b0, 32'h20, 32'h0, 4'hF, 1'b0);

        // Reset during RESP must not commit the store.
        @(negedge clk);
        bus_a.req = 1'b1; bus_a.we = 1'b1; bus_a.addr = 32'h20; bus_a.wdata = v2;
        @(posedge clk); #1;
        cyc = 0;
        while (!bus_a.ack && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rst_resp_reached", bus_a.ack, 1);
        rst = 1'b1;
        bus_a.req = 1'b0;
        @(posedge clk); #1;
        check("rst_resp_busy_after", bus_a.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        txn("ld_20_resp", 1'b0, 32'h20, 32'h0, 4'hF, 1'b0);

        // Bus changes after acceptance must be ignored.
        txn("st_24_scr", 1'b1, 32'h24, $urandom, 4'hF, 1'b1);
        txn("ld_24", 1'b0, 32'h24, 32'h0, 4'hF, 1'b0);
        txn("ld_64", 1'b0, 32'h64, 32'h0, 4'hF, 1'b0);

`ifdef MEM_RESP_BYTE_STROBE_EN
        txn("st_30", 1'b1, 32'h30, 32'h11223344, 4'hF, 1'b0);
        txn("st_30_be", 1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, 1'b0);
        txn("ld_30_be", 1'b0, 32'h30, 32'h0, 4'hF, 1'b0);
        check("be_literal", model_mem[12], 32'h11BB33DD);
        txn("st_30_be0", 1'b1, 32'h30, 32'hFFFFFFFF, 4'b0000, 1'b0);
        txn("ld_30_be0", 1'b0, 32'h30, 32'h0, 4'hF, 1'b0);
`endif

        // Randomized traffic over the prefilled window plus error addresses.
        for (int i = 0; i < 30; i++) begin
            int kind;
            kind = $urandom_range(0, 9);
            a = 32'h40 + 32'(4 * $urandom_range(0, 15));
            if (kind == 8) a = a + 32'($urandom_range(1, 3));
            if (kind == 9) a = 32'(4 * (DEPTH + $urandom_range(0, 1000)));
            d = $urandom;
            txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, d,
                4'($urandom), ($urandom_range(0, 3) == 0));
        end

        // Zero-wait instance: prime two words, then back-to-back loads with req held.
        vb[0] = $urandom;
        vb[1] = $urandom;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus_b.req = 1'b1; bus_b.we = 1'b1; bus_b.addr = 32'(4 * i); bus_b.wdata = vb[i];
            @(posedge clk); #1;
            check("b_st_ack", bus_b.ack, 1);
            bus_b.req = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        bus_b.req = 1'b1; bus_b.we = 1'b0; bus_b.addr = 32'h0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            ack_seq[c]  = bus_b.ack;
            busy_seq[c] = bus_b.busy;
            if (c == 0) begin
                check("b_ld0_rdata", bus_b.rdata, vb[0]);
                bus_b.addr = 32'h4;
            end
            if (c == 2) begin
                check("b_ld4_rdata", bus_b.rdata, vb[1]);
                bus_b.req = 1'b0;
            end
        end
        check("b_ack_pattern", 32'(ack_seq), 32'b0101);
        check("b_busy_pattern", 32'(busy_seq), 32'b0101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
